// File: rtl/wm8731_cfg_seq_if.sv
// Control and 2-wire bus signals of the WM8731 configuration sequencer.
// The runtime write port exists only when CFG_USER_WR_EN is defined.
interface wm8731_cfg_seq_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] cur_idx;
  logic       scl;
  logic       sda_oe;
  logic       sda_i;
`ifdef CFG_USER_WR_EN
  logic       wr_req;
  logic [6:0] wr_addr;
  logic [8:0] wr_data;
  logic       wr_ack;

  modport master (
    input  start, sda_i, wr_req, wr_addr, wr_data,
    output busy, done, error, cur_idx, scl, sda_oe, wr_ack
  );
  modport slave (
    output start, sda_i, wr_req, wr_addr, wr_data,
    input  busy, done, error, cur_idx, scl, sda_oe, wr_ack
  );
`else
  modport master (
    input  start, sda_i,
    output busy, done, error, cur_idx, scl, sda_oe
  );
  modport slave (
    output start, sda_i,
    input  busy, done, error, cur_idx, scl, sda_oe
  );
`endif
endinterface

// File: rtl/wm8731_cfg_seq.sv
// WM8731 power-up configuration sequencer: writes an 11-entry register table over I2C.
// Optional runtime single-register writes are enabled with `define CFG_USER_WR_EN.
module wm8731_cfg_seq #(
  parameter int         CLK_DIV   = 125,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  wm8731_cfg_seq_if.master bus
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [QW-1:0] Q_LAST   = QW'(CLK_DIV - 1);
  localparam logic [RW-1:0] R_LAST   = RW'(MAX_RETRY);
  localparam logic [3:0]    LAST_IDX = 4'd10;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_BYTE, ST_STOP, ST_GAP, ST_NEXT, ST_FIN
  } state_t;

  state_t          state_r, state_s;
  logic [QW-1:0]   q_cnt_r;
  logic [1:0]      qtr_r;
  logic [3:0]      bit_r;
  logic [1:0]      byte_r;
  logic [3:0]      idx_r;
  logic [RW-1:0]   retry_r;
  logic            nack_r;
  logic            scl_r, sda_oe_r, busy_r, done_r, error_r;

  logic            q_end_s, timed_s, ack_end_s, abort_s;
  logic            start_ok_s, user_ok_s, user_s;
  logic [15:0]     entry_s;
  logic [7:0]      byte_s;
  logic            bit_val_s, scl_s, sda_oe_s;

  // Register table, each entry {reg_addr[6:0], reg_data[8:0]}; entry 0 resets the codec.
  function automatic logic [15:0] table_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    table_entry = {7'h0F, 9'h000};
      4'd1:    table_entry = {7'h06, 9'h000};
      4'd2:    table_entry = {7'h00, 9'h017};
      4'd3:    table_entry = {7'h01, 9'h017};
      4'd4:    table_entry = {7'h02, 9'h079};
      4'd5:    table_entry = {7'h03, 9'h079};
      4'd6:    table_entry = {7'h04, 9'h012};
      4'd7:    table_entry = {7'h05, 9'h000};
      4'd8:    table_entry = {7'h07, 9'h002};
      4'd9:    table_entry = {7'h08, 9'h000};
      4'd10:   table_entry = {7'h09, 9'h001};
      default: table_entry = 16'h0000;
    endcase
  endfunction

  function automatic logic [7:0] frame_byte(input logic [1:0] sel, input logic [15:0] ent);
    case (sel)
      2'd0:    frame_byte = {DEV_ADDR, 1'b0};
      2'd1:    frame_byte = ent[15:8];
      default: frame_byte = ent[7:0];
    endcase
  endfunction

  assign q_end_s    = (q_cnt_r == Q_LAST);
  assign ack_end_s  = q_end_s && (qtr_r == 2'd3) && (bit_r == 4'd8);
  assign abort_s    = nack_r && (retry_r == R_LAST);
  assign timed_s    = (state_r == ST_START) || (state_r == ST_BYTE) ||
                      (state_r == ST_STOP)  || (state_r == ST_GAP);
  assign start_ok_s = (state_r == ST_IDLE) && bus.start;

`ifdef CFG_USER_WR_EN
  logic       user_r, wr_ack_r;
  logic [6:0] wr_addr_r;
  logic [8:0] wr_data_r;

  // wr_ack_r blocks re-acceptance of the request still held in the ack cycle.
  assign user_ok_s = (state_r == ST_IDLE) && !bus.start && bus.wr_req && done_r && !wr_ack_r;
  assign user_s    = user_r;
  assign entry_s   = user_r ? {wr_addr_r, wr_data_r} : table_entry(idx_r);
  assign bus.wr_ack = wr_ack_r;

  // Runtime write request capture and completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      user_r    <= 1'b0;
      wr_ack_r  <= 1'b0;
      wr_addr_r <= 7'h00;
      wr_data_r <= 9'h000;
    end else begin
      wr_ack_r <= (state_r == ST_FIN) && user_r;
      if (start_ok_s) begin
        user_r <= 1'b0;
      end else if (user_ok_s) begin
        user_r    <= 1'b1;
        wr_addr_r <= bus.wr_addr;
        wr_data_r <= bus.wr_data;
      end
    end
  end
`else
  assign user_ok_s = 1'b0;
  assign user_s    = 1'b0;
  assign entry_s   = table_entry(idx_r);
`endif

  assign byte_s    = frame_byte(byte_r, entry_s);
  assign bit_val_s = byte_s[3'd7 - bit_r[2:0]];

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; transitions out of timed states happen only on quarter ends.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s || user_ok_s) state_s = ST_START;
        else                         state_s = ST_IDLE;
      end
      ST_START: begin
        if (q_end_s && (qtr_r == 2'd1)) state_s = ST_BYTE;
        else                            state_s = ST_START;
      end
      ST_BYTE: begin
        if (ack_end_s && (nack_r || (byte_r == 2'd2))) state_s = ST_STOP;
        else                                           state_s = ST_BYTE;
      end
      ST_STOP: begin
        if (q_end_s && (qtr_r == 2'd2)) state_s = abort_s ? ST_FIN : ST_GAP;
        else                            state_s = ST_STOP;
      end
      ST_GAP: begin
        if (q_end_s && (qtr_r == 2'd3)) begin
          if (nack_r)      state_s = ST_START;
          else if (user_s) state_s = ST_FIN;
          else             state_s = ST_NEXT;
        end else begin
          state_s = ST_GAP;
        end
      end
      ST_NEXT: begin
        if (idx_r == LAST_IDX) state_s = ST_FIN;
        else                   state_s = ST_START;
      end
      ST_FIN:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Bus line levels for the current state/quarter; registered below.
  always_comb begin
    scl_s    = 1'b1;
    sda_oe_s = 1'b0;
    case (state_r)
      ST_START: begin
        scl_s    = 1'b1;
        sda_oe_s = 1'b1;
      end
      ST_BYTE: begin
        scl_s    = qtr_r[1];
        sda_oe_s = (bit_r == 4'd8) ? 1'b0 : ~bit_val_s;
      end
      ST_STOP: begin
        scl_s    = (qtr_r != 2'd0);
        sda_oe_s = (qtr_r != 2'd2);
      end
      default: begin
        scl_s    = 1'b1;
        sda_oe_s = 1'b0;
      end
    endcase
  end

  // Timing counters, frame position, retry bookkeeping and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_cnt_r  <= '0;
      qtr_r    <= 2'd0;
      bit_r    <= 4'd0;
      byte_r   <= 2'd0;
      idx_r    <= 4'd0;
      retry_r  <= '0;
      nack_r   <= 1'b0;
      scl_r    <= 1'b1;
      sda_oe_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      scl_r    <= scl_s;
      sda_oe_r <= sda_oe_s;

      if (!timed_s) begin
        q_cnt_r <= '0;
        qtr_r   <= 2'd0;
      end else if (q_end_s) begin
        q_cnt_r <= '0;
        qtr_r   <= (state_s != state_r) ? 2'd0 : qtr_r + 2'd1;
      end else begin
        q_cnt_r <= q_cnt_r + QW'(1);
      end

      if (state_r == ST_START) begin
        bit_r  <= 4'd0;
        byte_r <= 2'd0;
        nack_r <= 1'b0;
      end else if ((state_r == ST_BYTE) && q_end_s) begin
        if ((qtr_r == 2'd2) && (bit_r == 4'd8)) nack_r <= bus.sda_i;
        if (qtr_r == 2'd3) begin
          if (bit_r == 4'd8) begin
            bit_r  <= 4'd0;
            byte_r <= byte_r + 2'd1;
          end else begin
            bit_r <= bit_r + 4'd1;
          end
        end
      end

      if (start_ok_s || user_ok_s) begin
        retry_r <= '0;
      end else if ((state_r == ST_STOP) && q_end_s && (qtr_r == 2'd2) && nack_r && !abort_s) begin
        retry_r <= retry_r + RW'(1);
      end else if ((state_r == ST_GAP) && q_end_s && (qtr_r == 2'd3) && !nack_r) begin
        retry_r <= '0;
      end

      if (start_ok_s) begin
        idx_r <= 4'd0;
      end else if ((state_r == ST_NEXT) && (idx_r != LAST_IDX)) begin
        idx_r <= idx_r + 4'd1;
      end

      // FIN is reached with nack_r set only through an exhausted entry.
      if (start_ok_s) begin
        busy_r  <= 1'b1;
        done_r  <= 1'b0;
        error_r <= 1'b0;
      end else if (user_ok_s) begin
        busy_r  <= 1'b1;
        error_r <= 1'b0;
      end else if (state_r == ST_FIN) begin
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        error_r <= nack_r;
      end
    end
  end

  assign bus.scl     = scl_r;
  assign bus.sda_oe  = sda_oe_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.error   = error_r;
  assign bus.cur_idx = idx_r;

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Bench for wm8731_cfg_seq: an I2C decoder/slave model checks every frame against a queue
// of expected {dev, byte1, byte2, nack} records pushed by the stimulus process.
module tb_wm8731_cfg_seq;

  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slave_pull = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  wm8731_cfg_seq_if bus();
  assign bus.sda_i = ~(bus.sda_oe | slave_pull);

  wm8731_cfg_seq #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A), .MAX_RETRY(3)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed {addr,data[8]} / data[7:0] byte pairs of the register table.
  logic [15:0] tbl [0:10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                              16'h0812, 16'h0A00, 16'h0E02, 16'h1000, 16'h1201};
  logic [24:0] exp_q [$];
  int          nack_left [0:127];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decoder and slave model state
  logic       prev_scl = 1'b1, prev_sda = 1'b1, in_frame = 1'b0, fnack = 1'b0, rise_seen = 1'b0;
  logic [7:0] cur_byte = 8'h00, f0 = 8'h00, f1 = 8'h00, f2 = 8'h00;
  int         bitpos = 0, bytenum = 0, last_rise = 0, meas_left = 0;

  always @(negedge clk) begin
    logic scl_now, sda_now;
    scl_now = bus.scl;
    sda_now = bus.sda_i;
    if (reset) begin
      in_frame = 1'b0;
      slave_pull <= 1'b0;
    end else if (scl_now && prev_scl && prev_sda && !sda_now) begin
      in_frame = 1'b1; bitpos = 0; bytenum = 0; fnack = 1'b0; rise_seen = 1'b0;
    end else if (scl_now && prev_scl && !prev_sda && sda_now) begin
      if (in_frame) begin
        if (bytenum != 3) begin
          n_checks++; n_fail++;
          $display("FAIL frame_len: got %0d bytes expected 3", bytenum);
        end else if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_unexpected: got %h %h %h nack=%0b expected none", f0, f1, f2, fnack);
        end else begin
          check("frame", {7'd0, f0, f1, f2, fnack}, {7'd0, exp_q.pop_front()});
        end
      end
      in_frame = 1'b0;
      slave_pull <= 1'b0;
    end else if (in_frame) begin
      if (!prev_scl && scl_now) begin
        if (rise_seen && bytenum == 0 && meas_left > 0) check("scl_period", cyc - last_rise, 4 * CLK_DIV);
        rise_seen = 1'b1;
        last_rise = cyc;
        if (bytenum < 3) begin
          if (bitpos < 8) begin
            cur_byte = {cur_byte[6:0], sda_now};
            bitpos++;
          end else begin
            if (sda_now) fnack = 1'b1;
            case (bytenum)
              0: f0 = cur_byte;
              1: f1 = cur_byte;
              default: f2 = cur_byte;
            endcase
            bytenum++;
            bitpos = 0;
          end
        end
      end else if (prev_scl && !scl_now) begin
        if (rise_seen && bytenum == 0 && meas_left > 0) begin
          check("scl_high", cyc - last_rise, 2 * CLK_DIV);
          meas_left--;
        end
        if (bytenum < 3 && bitpos == 8) begin
          if (bytenum == 0) slave_pull <= (cur_byte == 8'h34);
          else if (bytenum == 1) slave_pull <= 1'b1;
          else if (nack_left[f1[7:1]] > 0) begin
            nack_left[f1[7:1]]--;
            slave_pull <= 1'b0;
          end else slave_pull <= 1'b1;
        end else begin
          slave_pull <= 1'b0;
        end
      end
    end
    prev_scl = scl_now;
    prev_sda = sda_now;
  end

  task automatic push_entry(input int i, input logic nack);
    exp_q.push_back({8'h34, tbl[i], nack});
  endtask

  task automatic pulse_start;
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!bus.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: done still 0 after %0d cycles", limit);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
`ifdef CFG_USER_WR_EN
    bus.wr_req = 1'b0; bus.wr_addr = 7'h00; bus.wr_data = 9'h000;
`endif
    for (int i = 0; i < 128; i++) nack_left[i] = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_scl", bus.scl, 1); check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_busy", bus.busy, 0); check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0); check("rst_cur_idx", bus.cur_idx, 0);
    reset = 1'b0;

    // Full table with an always-ACKing slave, plus SCL timing on the first address byte
    meas_left = 6;
    for (int i = 0; i <= 10; i++) push_entry(i, 1'b0);
    pulse_start;
    check("t1_busy_after_start", bus.busy, 1);
    check("t1_done_cleared", bus.done, 0);
    wait_done(20000);
    check("t1_done", bus.done, 1); check("t1_error", bus.error, 0);
    check("t1_busy", bus.busy, 0); check("t1_cur_idx", bus.cur_idx, 10);
    check("t1_queue_empty", exp_q.size(), 0);

    // Entry 3 NACKed twice, then the sequence continues; a start while busy is ignored
    nack_left[1] = 2;
    for (int i = 0; i <= 2; i++) push_entry(i, 1'b0);
    push_entry(3, 1'b1); push_entry(3, 1'b1);
    for (int i = 3; i <= 10; i++) push_entry(i, 1'b0);
    pulse_start;
    repeat (1000) @(negedge clk);
    pulse_start;
    wait_done(20000);
    check("t2_done", bus.done, 1); check("t2_error", bus.error, 0);
    check("t2_queue_empty", exp_q.size(), 0);

    // Entry 5 always NACKed: four attempts then abort
    nack_left[3] = 1000;
    for (int i = 0; i <= 4; i++) push_entry(i, 1'b0);
    for (int k = 0; k < 4; k++) push_entry(5, 1'b1);
    pulse_start;
    wait_done(20000);
    repeat (300) @(negedge clk);
    check("t3_done", bus.done, 1); check("t3_error", bus.error, 1);
    check("t3_busy", bus.busy, 0); check("t3_cur_idx", bus.cur_idx, 5);
    check("t3_queue_empty", exp_q.size(), 0);
    nack_left[3] = 0;

    // Reset in the middle of the second byte of entry 0, then a fresh run
    pulse_start;
    begin
      int n;
      n = 0;
      while (!(in_frame && bytenum == 1 && bitpos == 3) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("t4_reached_byte2", n < 2000, 1);
    end
    @(posedge clk) #1 reset = 1'b1;
    @(posedge clk) #1;
    check("t4_rst_scl", bus.scl, 1); check("t4_rst_sda_oe", bus.sda_oe, 0);
    check("t4_rst_busy", bus.busy, 0);
    reset = 1'b0;
    for (int i = 0; i <= 10; i++) push_entry(i, 1'b0);
    pulse_start;
    wait_done(20000);
    check("t4_done", bus.done, 1); check("t4_error", bus.error, 0);
    check("t4_queue_empty", exp_q.size(), 0);

`ifdef CFG_USER_WR_EN
    // Runtime write of register 02 = 06F after the table ran
    begin
      int acks;
      acks = 0;
      exp_q.push_back({8'h34, 8'h04, 8'h6F, 1'b0});
      @(negedge clk);
      bus.wr_addr = 7'h02; bus.wr_data = 9'h06F; bus.wr_req = 1'b1;
      for (int n = 0; n < 1500; n++) begin
        @(negedge clk);
        bus.start = (n == 50);
        if (bus.wr_ack) begin
          acks++;
          bus.wr_req = 1'b0;
        end
      end
      check("t5_wr_ack_count", acks, 1);
      check("t5_done", bus.done, 1); check("t5_error", bus.error, 0);
      check("t5_busy", bus.busy, 0); check("t5_queue_empty", exp_q.size(), 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
